// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, exception codes, FSM states.
package mem_access_unit_pkg;

  localparam int unsigned AluOpW   = 8;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned ExcCodeW = 5;

  typedef logic [AluOpW-1:0]   aluop_t;
  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [ExcCodeW-1:0] exc_code_t;

  localparam aluop_t OP_NOP = 8'b0000_0000;
  localparam aluop_t OP_LB  = 8'b1110_0000;
  localparam aluop_t OP_LH  = 8'b1110_0001;
  localparam aluop_t OP_LW  = 8'b1110_0011;
  localparam aluop_t OP_LBU = 8'b1110_0100;
  localparam aluop_t OP_LHU = 8'b1110_0101;
  localparam aluop_t OP_SB  = 8'b1110_1000;
  localparam aluop_t OP_SH  = 8'b1110_1001;
  localparam aluop_t OP_SW  = 8'b1110_1011;

  localparam exc_code_t EC_Int     = 5'd0;
  localparam exc_code_t EC_AdEL    = 5'd4;
  localparam exc_code_t EC_AdES    = 5'd5;
  localparam exc_code_t EC_DBE     = 5'd7;
  localparam exc_code_t EC_Syscall = 5'd8;
  localparam exc_code_t EC_None    = 5'h1f;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic [1:0] {SzNone, SzByte, SzHalf, SzWord} size_e;

  function automatic logic is_load(input aluop_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic is_store(input aluop_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic size_e op_size(input aluop_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SzByte;
      OP_LH, OP_LHU, OP_SH: return SzHalf;
      OP_LW, OP_SW:         return SzWord;
      default:              return SzNone;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed little-endian lane of a bus read word and sign/zero-extends it.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (aluop)
      OP_LB:   ldata = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  ldata = {24'h0, byte_v};
      OP_LH:   ldata = {{16{half_v[15]}}, half_v};
      OP_LHU:  ldata = {16'h0, half_v};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack data-bus transaction per memory op, stalling the
// pipeline until it completes, with alignment and bus-timeout exception reporting.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        cpu_clk_75M,
  input  logic        cpu_rst_n,
  input  aluop_t      mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  reg_addr_t   mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  exc_code_t   exc_code_i,
  input  logic        flush,
  input  logic        wb_stall,
  output reg_addr_t   wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output exc_code_t   exc_code_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        stallreq_mem,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic [31:0]     lbuf_q;
  logic            kill_q, err_q;

  logic        load_op, store_op, mem_op, misaligned, exc_in, start;
  size_e       size;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_val;

  always_comb begin
    load_op  = is_load(mem_aluop);
    store_op = is_store(mem_aluop);
    mem_op   = load_op | store_op;
    size     = op_size(mem_aluop);
    misaligned = mem_op && (((size == SzHalf) && mem_mem_addr[0]) ||
                            ((size == SzWord) && (mem_mem_addr[1:0] != 2'b00)));
    case (size)
      SzByte: begin
        be_c    = 4'b0001 << mem_mem_addr[1:0];
        wdata_c = {4{mem_reg2[7:0]}};
      end
      SzHalf: begin
        be_c    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_reg2[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = mem_reg2;
      end
    endcase
  end

  assign exc_in = (exc_code_i != EC_None);
  assign start  = (state_q == StIdle) && mem_op && !exc_in && !misaligned && !flush;

  mem_load_align u_load_align (
    .aluop   (mem_aluop),
    .addr_lo (mem_mem_addr[1:0]),
    .rdata   (dbus_rdata),
    .ldata   (load_val)
  );

  always_comb begin
    wb_wd          = mem_wd;
    wb_wreg        = mem_wreg;
    wb_wdata       = mem_wdata;
    exc_code_o     = EC_None;
    exc_badvaddr_o = '0;
    stallreq_mem   = 1'b0;
    unique case (state_q)
      StIdle: begin
        stallreq_mem = start;
        if (exc_in) begin
          exc_code_o = exc_code_i;
        end else if (misaligned) begin
          exc_code_o     = load_op ? EC_AdEL : EC_AdES;
          exc_badvaddr_o = mem_mem_addr;
          wb_wreg        = 1'b0;
        end
      end
      StBusy: begin
        stallreq_mem = 1'b1;
        wb_wreg      = 1'b0;
      end
      StDone: begin
        if (load_op) wb_wdata = lbuf_q;
        wb_wreg = mem_wreg && !err_q && !kill_q;
        // A killed transaction reports nothing, not even its own bus error.
        if (err_q && !kill_q) begin
          exc_code_o     = EC_DBE;
          exc_badvaddr_o = mem_mem_addr;
        end
      end
      default: ;
    endcase
    if (!cpu_rst_n) begin
      stallreq_mem = 1'b0;
      wb_wreg      = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= StIdle;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_be    <= 4'b0000;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      lbuf_q     <= '0;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          kill_q <= 1'b0;
          err_q  <= 1'b0;
          if (start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= store_op;
            dbus_be    <= be_c;
            dbus_addr  <= {mem_mem_addr[31:2], 2'b00};
            dbus_wdata <= wdata_c;
            cnt_q      <= '0;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q + 1'b1;
          // Flush only marks the result; the bus handshake must still finish.
          if (flush) kill_q <= 1'b1;
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            lbuf_q   <= load_val;
            state_q  <= StDone;
          end else if (cnt_q == TO_W'(BUS_TIMEOUT - 1)) begin
            dbus_req <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (flush || !wb_stall) begin
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
